// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared state type, tone constants and half-period helpers for the beeper
package beep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } beep_state_t;

  // Half-period divisors: a half period of an F Hz tone is CLK_HZ/(2F) cycles,
  // with "1 kHz" meaning 1024 Hz.
  localparam int TONE_512_DIV = 1024;
  localparam int TONE_1K_DIV  = 2048;

  function automatic int half_512(input int clk_hz);
    return clk_hz / TONE_512_DIV;
  endfunction

  function automatic int half_1k(input int clk_hz);
    return clk_hz / TONE_1K_DIV;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beep_tone_gen_if.sv
// rtl/beep_tone_gen_if.sv - request/status bundle between timer and beeper; BEEP_MUTE_EN adds mute
interface beep_tone_gen_if;

  logic beep512Hz;
  logic beep1kHz;
  logic buzzer;
  logic busy;
  logic tone_1k;
  logic done;
`ifdef BEEP_MUTE_EN
  logic mute;
`endif

  // Requester side: raises request levels, watches the status.
  modport master (
`ifdef BEEP_MUTE_EN
    output mute,
`endif
    output beep512Hz,
    output beep1kHz,
    input  buzzer,
    input  busy,
    input  tone_1k,
    input  done
  );

  // Beeper side.
  modport slave (
`ifdef BEEP_MUTE_EN
    input  mute,
`endif
    input  beep512Hz,
    input  beep1kHz,
    output buzzer,
    output busy,
    output tone_1k,
    output done
  );

endinterface

// File: rtl/beep_div.sv
// rtl/beep_div.sv - loadable half-period divider with tone toggle and period-end strobe
module beep_div #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          restart,
  input  logic [DW-1:0] last,
  output logic          tone_next,
  output logic          period_end
);

  logic [DW-1:0] count;
  logic          tone;
  logic          wrap;

  // A period is one high half followed by one low half, so it closes when the
  // low half wraps; the owner sees that as the end of a full tone period.
  always_comb begin
    wrap       = (count == last);
    period_end = run & ~restart & wrap & ~tone;
    if (restart) begin
      tone_next = 1'b1;
    end else if (!run) begin
      tone_next = 1'b0;
    end else if (wrap) begin
      tone_next = ~tone;
    end else begin
      tone_next = tone;
    end
  end

  // Divider count and tone phase; restart wins and begins a fresh high half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tone  <= 1'b0;
    end else if (restart) begin
      count <= '0;
      tone  <= 1'b1;
    end else if (!run) begin
      count <= '0;
      tone  <= 1'b0;
    end else if (wrap) begin
      count <= '0;
      tone  <= ~tone;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - piezo beep burst generator; BEEP_MUTE_EN adds a registered mute gate
module beep_tone_gen
  import beep_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BURST_512 = 256,
  parameter int BURST_1K  = 1024
) (
  input logic            clk,
  input logic            rst_n,
  beep_tone_gen_if.slave bus
);

  localparam int HALF_512 = half_512(CLK_HZ);
  localparam int HALF_1K  = half_1k(CLK_HZ);
  localparam int DW       = width_for(HALF_512);
  localparam int PW       = width_for(max_int(BURST_512, BURST_1K));

  localparam logic [DW-1:0] LAST_HALF_512 = DW'(HALF_512 - 1);
  localparam logic [DW-1:0] LAST_HALF_1K  = DW'(HALF_1K - 1);
  localparam logic [PW-1:0] LAST_PER_512  = PW'(BURST_512 - 1);
  localparam logic [PW-1:0] LAST_PER_1K   = PW'(BURST_1K - 1);

  // A clock too slow for a two-cycle half period cannot produce the tones.
  if (HALF_1K < 2 || HALF_512 < 2) begin : g_half_check
    $error("beep_tone_gen: CLK_HZ gives a half period below 2 cycles");
  end

  beep_state_t   state;
  logic          req512_q;
  logic          req1k_q;
  logic [PW-1:0] period;
  logic          busy_q;
  logic          tone_1k_q;
  logic          done_q;
  logic          buzzer_q;

  logic          rise_512;
  logic          rise_1k;
  logic          start;
  logic          last_period;
  logic          finish;
  logic          buzzer_next;
  logic          mute_gate;
  logic [DW-1:0] div_last;
  logic          div_tone_next;
  logic          div_period_end;

`ifdef BEEP_MUTE_EN
  assign mute_gate = bus.mute;
`else
  assign mute_gate = 1'b0;
`endif

  // Request edges, burst (re)start decision and next buzzer level.
  always_comb begin
    rise_512 = bus.beep512Hz & ~req512_q;
    rise_1k  = bus.beep1kHz & ~req1k_q;
    // While playing, a 512 edge may only restart a 512 burst; 1k always wins.
    if (state == IDLE) begin
      start = rise_1k | rise_512;
    end else begin
      start = rise_1k | (rise_512 & ~tone_1k_q);
    end
    last_period = (period == (tone_1k_q ? LAST_PER_1K : LAST_PER_512));
    finish      = (state == PLAY) & div_period_end & last_period & ~start;
    div_last    = tone_1k_q ? LAST_HALF_1K : LAST_HALF_512;
    if (start) begin
      buzzer_next = 1'b1;
    end else if (finish || state == IDLE) begin
      buzzer_next = 1'b0;
    end else begin
      buzzer_next = div_tone_next;
    end
  end

  beep_div #(
    .DW(DW)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state == PLAY),
    .restart   (start),
    .last      (div_last),
    .tone_next (div_tone_next),
    .period_end(div_period_end)
  );

  // Burst FSM with period counter, edge-detect history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req512_q  <= 1'b0;
      req1k_q   <= 1'b0;
      period    <= '0;
      busy_q    <= 1'b0;
      tone_1k_q <= 1'b0;
      done_q    <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      req512_q <= bus.beep512Hz;
      req1k_q  <= bus.beep1kHz;
      done_q   <= 1'b0;
      buzzer_q <= buzzer_next & ~mute_gate;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PLAY;
            busy_q    <= 1'b1;
            tone_1k_q <= rise_1k;
            period    <= '0;
          end
        end
        PLAY: begin
          if (start) begin
            // Pre-emption or same-tone retrigger: no done pulse.
            tone_1k_q <= rise_1k;
            period    <= '0;
          end else if (div_period_end) begin
            if (last_period) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              period <= period + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.buzzer  = buzzer_q;
  assign bus.busy    = busy_q;
  assign bus.tone_1k = tone_1k_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_beep_tone_gen.sv
// tb/tb_beep_tone_gen.sv - self-checking bench for beep_tone_gen; define BEEP_MUTE_EN to cover mute
module tb_beep_tone_gen;

  localparam int CLK_HZ = 20480;
  localparam int B512   = 4;
  localparam int B1K    = 8;
  localparam int H512   = CLK_HZ / 1024;
  localparam int H1K    = CLK_HZ / 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   mute_v = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  beep_tone_gen_if bus ();

  beep_tone_gen #(
    .CLK_HZ   (CLK_HZ),
    .BURST_512(B512),
    .BURST_1K (B1K)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: burst described by its start edge and tone only.
  int m_k     = 0;
  int m_start = 0;
  bit m_busy, m_tone, m_done, m_buzz, m_p512, m_p1k;

  function automatic int half_of(input bit t);
    return t ? H1K : H512;
  endfunction

  function automatic int len_of(input bit t);
    return 2 * half_of(t) * (t ? B1K : B512);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tone = 0; m_done = 0; m_buzz = 0; m_p512 = 0; m_p1k = 0;
  endtask

  task automatic model_edge(input bit b512, input bit b1k, input bit mute);
    bit r512, r1k, ending;
    m_k++;
    r512   = b512 && !m_p512;
    r1k    = b1k && !m_p1k;
    m_p512 = b512;
    m_p1k  = b1k;
    ending = m_busy && ((m_k - m_start) == len_of(m_tone));
    m_done = 0;
    if (r1k) begin
      m_busy = 1; m_tone = 1; m_start = m_k;
    end else if (r512 && (!m_busy || !m_tone)) begin
      m_busy = 1; m_tone = 0; m_start = m_k;
    end else if (ending) begin
      m_busy = 0; m_done = 1;
    end
    m_buzz = m_busy && ((((m_k - m_start) / half_of(m_tone)) % 2) == 0) && !mute;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: edge %0d got %0d required %0d", name, m_k, act, exp);
  endtask

  task automatic check_model();
    check("model.busy", 32'(bus.busy), 32'(m_busy));
    check("model.buzzer", 32'(bus.buzzer), 32'(m_buzz));
    check("model.tone_1k", 32'(bus.tone_1k), 32'(m_tone));
    check("model.done", 32'(bus.done), 32'(m_done));
  endtask

  // Drive inputs, take one rising edge, advance model, compare just after.
  task automatic tick(input bit b512, input bit b1k);
    bus.beep512Hz = b512;
    bus.beep1kHz  = b1k;
`ifdef BEEP_MUTE_EN
    bus.mute = mute_v;
`endif
    @(posedge clk);
    model_edge(b512, b1k, mute_v);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic measure(input bit b512, input bit b1k, input int hold, input int total,
                         output int highs, output int busy_cnt, output int done_cnt,
                         output int done_tone);
    bit prev;
    prev = 0; highs = 0; busy_cnt = 0; done_cnt = 0; done_tone = -1;
    for (int c = 0; c < total; c++) begin
      tick((c < hold) ? b512 : 1'b0, (c < hold) ? b1k : 1'b0);
      if (bus.buzzer && !prev) highs++;
      prev = bus.buzzer;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_tone = int'(bus.tone_1k);
      end
    end
  endtask

  typedef struct {
    bit b512;
    bit b1k;
    int hold;
    bit busy;
    bit buzz;
    bit tone;
    bit done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit a, input bit b, input int h,
                     input bit bs, input bit bz, input bit t, input bit d);
    vec_t v;
    v.b512 = a; v.b1k = b; v.hold = h; v.busy = bs; v.buzz = bz; v.tone = t; v.done = d;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, bcnt, dcnt, dtone;
    bit l512, l1k;

    // 512 burst walk-through
    add(0,0,2,   0,0,0,0);
    add(1,0,1,   1,1,0,0);
    add(0,0,19,  1,1,0,0);
    add(0,0,1,   1,0,0,0);
    add(0,0,19,  1,0,0,0);
    add(0,0,1,   1,1,0,0);
    add(0,0,119, 1,0,0,0);
    add(0,0,1,   0,0,0,1);
    add(0,0,1,   0,0,0,0);
    // 1k burst from a level held 1000 cycles
    add(0,1,1,   1,1,1,0);
    add(0,1,10,  1,0,1,0);
    add(0,1,149, 1,0,1,0);
    add(0,1,1,   0,0,1,1);
    add(0,1,839, 0,0,1,0);
    add(0,0,1,   0,0,1,0);
    // 1k pre-empts a 512 burst 50 cycles in
    add(1,0,1,   1,1,0,0);
    add(0,0,49,  1,1,0,0);
    add(0,1,1,   1,1,1,0);
    add(0,1,159, 1,0,1,0);
    add(0,1,1,   0,0,1,1);
    add(0,0,3,   0,0,1,0);
    // simultaneous edges pick 1k; a later 512 edge is dropped
    add(1,1,1,   1,1,1,0);
    add(1,1,39,  1,0,1,0);
    add(0,0,20,  1,0,1,0);
    add(1,0,1,   1,1,1,0);
    add(1,0,99,  1,0,1,0);
    add(1,0,1,   0,0,1,1);
    add(0,0,2,   0,0,1,0);

    bus.beep512Hz = 0;
    bus.beep1kHz  = 0;
`ifdef BEEP_MUTE_EN
    bus.mute = 0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.buzzer", 32'(bus.buzzer), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.tone_1k", 32'(bus.tone_1k), 0);
    check("reset.done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].hold; c++) tick(tbl[i].b512, tbl[i].b1k);
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("vec%0d.buzzer", i), 32'(bus.buzzer), 32'(tbl[i].buzz));
      check($sformatf("vec%0d.tone_1k", i), 32'(bus.tone_1k), 32'(tbl[i].tone));
      check($sformatf("vec%0d.done", i), 32'(bus.done), 32'(tbl[i].done));
    end

    // Whole-burst shape measurements
    measure(1, 0, 1, 200, highs, bcnt, dcnt, dtone);
    check("b512.highs", 32'(highs), B512);
    check("b512.busy_cycles", 32'(bcnt), 2 * H512 * B512);
    check("b512.done_count", 32'(dcnt), 1);
    check("b512.done_tone", 32'(dtone), 0);
    measure(0, 1, 1000, 1100, highs, bcnt, dcnt, dtone);
    check("b1k.highs", 32'(highs), B1K);
    check("b1k.busy_cycles", 32'(bcnt), 2 * H1K * B1K);
    check("b1k.done_count", 32'(dcnt), 1);
    check("b1k.done_tone", 32'(dtone), 1);
`ifdef BEEP_MUTE_EN
    mute_v = 1;
    measure(1, 0, 1, 200, highs, bcnt, dcnt, dtone);
    mute_v = 0;
    check("mute.highs", 32'(highs), 0);
    check("mute.busy_cycles", 32'(bcnt), 2 * H512 * B512);
    check("mute.done_count", 32'(dcnt), 1);
`endif

    // Asynchronous reset 37 cycles into a 1k burst with the request held
    for (int c = 0; c < 37; c++) tick(0, 1);
    check("rst.busy_before", 32'(bus.busy), 1);
    #2;
    rst_n = 0;
    #1;
    check("rst.buzzer", 32'(bus.buzzer), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.tone_1k", 32'(bus.tone_1k), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick(0, 1);
    check("rst.restart_busy", 32'(bus.busy), 1);
    check("rst.restart_buzzer", 32'(bus.buzzer), 1);
    check("rst.restart_tone", 32'(bus.tone_1k), 1);
    for (int c = 0; c < 170; c++) tick(0, 1);
    for (int c = 0; c < 5; c++) tick(0, 0);

    // Randomised request levels and pulses against the model
    l512 = 0;
    l1k  = 0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) l512 = ~l512;
      else if (r < 3) l1k = ~l1k;
      else if (r == 3) begin l512 = ~l512; l1k = ~l1k; end
`ifdef BEEP_MUTE_EN
      if ($urandom_range(0, 49) == 0) mute_v = ~mute_v;
`endif
      tick(l512, l1k);
    end
    mute_v = 0;
    for (int c = 0; c < 400; c++) tick(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
